seq_dot2_mac: RTL and testbench

SEQ_DOT2_MAC -- requirements
Module: seq_dot2_mac

---
 rtl/seq_dot2_mac_pkg.sv | 29 ++
 rtl/seq_dot2_mac_shift_mul.sv | 60 ++++++
 rtl/seq_dot2_mac.sv | 170 +++++++++++++++++
 tb/tb_seq_dot2_mac.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/seq_dot2_mac_pkg.sv
// ============================================================
// seq_dot2_mac_pkg: shared types and sizing helpers for seq_dot2_mac
// Rev 1.0
// ============================================================
`default_nettype none

package seq_dot2_mac_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_MUL_AB = 2'd1,
    S_MUL_CD = 2'd2,
    S_SUM    = 2'd3
  } state_t;

  localparam int DEF_W   = 4;
  localparam int LATENCY = 2 * DEF_W + 1;

  function automatic int default_rw(input int w);
    return 2 * w + 4;
  endfunction

  function automatic int mac_latency(input int w);
    return 2 * w + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/seq_dot2_mac_shift_mul.sv
// ============================================================
// seq_shift_mul: W-bit iterative shift-add multiplier, one bit per step
// Rev 1.0
// ============================================================
`default_nettype none

module seq_shift_mul #(
  parameter int W = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           load,
  input  logic           step,
  input  logic [W-1:0]   mcand,
  input  logic [W-1:0]   mplier,
  output logic [2*W-1:0] product,
  output logic [2*W-1:0] product_nxt
);

  logic [2*W-1:0] mcand_q, mcand_d;
  logic [W-1:0]   mplier_q, mplier_d;
  logic [2*W-1:0] prod_q, prod_d;
  logic [2*W-1:0] partial;

  // product_nxt is the value the current step will produce, so the caller can
  // capture a finished product on the same edge that reloads the multiplier.
  always_comb begin
    partial     = mplier_q[0] ? mcand_q : '0;
    product_nxt = prod_q + partial;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    prod_d      = prod_q;
    if (load) begin
      mcand_d  = {{W{1'b0}}, mcand};
      mplier_d = mplier;
      prod_d   = '0;
    end else if (step) begin
      prod_d   = product_nxt;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
    end
  end

  assign product = prod_q;

endmodule

`default_nettype wire

// File: rtl/seq_dot2_mac.sv
// ============================================================
// seq_dot2_mac: (a*b)+(c*d) multiply-accumulate on one shared multiplier
// Rev 1.0
// ============================================================
`default_nettype none

module seq_dot2_mac
  import seq_dot2_mac_pkg::*;
#(
  parameter int W  = 4,
  parameter int RW = default_rw(W)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          acc,
  input  logic          clr,
  input  logic [W-1:0]  a,
  input  logic [W-1:0]  b,
  input  logic [W-1:0]  c,
  input  logic [W-1:0]  d,
  output logic          busy,
  output logic          done,
  output logic [RW-1:0] result,
  output logic          ovf
);

  localparam int CW = (W > 2) ? $clog2(W) : 1;
  localparam int SW = 2 * W + 1;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [W-1:0]    opc_q, opc_d;
  logic [W-1:0]    opd_q, opd_d;
  logic            acc_op_q, acc_op_d;
  logic [2*W-1:0]  p_ab_q, p_ab_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [RW-1:0]   result_q, result_d;
  logic            ovf_q, ovf_d;

  logic            mul_load;
  logic            mul_step;
  logic [W-1:0]    mul_mcand;
  logic [W-1:0]    mul_mplier;
  logic [2*W-1:0]  mul_product;
  logic [2*W-1:0]  mul_product_nxt;

  logic [SW-1:0]   pair_sum;
  logic [RW:0]     acc_total;
  logic            last_step;

  seq_shift_mul #(
    .W (W)
  ) u_mul (
    .clk         (clk),
    .rst         (rst),
    .load        (mul_load),
    .step        (mul_step),
    .mcand       (mul_mcand),
    .mplier      (mul_mplier),
    .product     (mul_product),
    .product_nxt (mul_product_nxt)
  );

  // In IDLE the multiplier is loaded straight from the ports; later reloads use the latched c/d.
  assign mul_mcand  = (state_q == S_IDLE) ? a : opc_q;
  assign mul_mplier = (state_q == S_IDLE) ? b : opd_q;
  assign last_step  = (cnt_q == CW'(W - 1));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    opc_d    = opc_q;
    opd_d    = opd_q;
    acc_op_d = acc_op_q;
    p_ab_d   = p_ab_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    result_d = result_q;
    ovf_d    = ovf_q;
    mul_load = 1'b0;
    mul_step = 1'b0;

    pair_sum  = SW'(p_ab_q) + SW'(mul_product);
    acc_total = (RW+1)'(pair_sum) + (acc_op_q ? {1'b0, result_q} : '0);

    case (state_q)
      S_IDLE: begin
        if (clr) begin
          result_d = '0;
          ovf_d    = 1'b0;
        end else if (start) begin
          opc_d    = c;
          opd_d    = d;
          acc_op_d = acc;
          mul_load = 1'b1;
          cnt_d    = '0;
          busy_d   = 1'b1;
          state_d  = S_MUL_AB;
        end
      end
      S_MUL_AB: begin
        mul_step = 1'b1;
        if (last_step) begin
          p_ab_d   = mul_product_nxt;
          mul_load = 1'b1;
          cnt_d    = '0;
          state_d  = S_MUL_CD;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_MUL_CD: begin
        mul_step = 1'b1;
        if (last_step) begin
          cnt_d   = '0;
          state_d = S_SUM;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_SUM: begin
        result_d = acc_total[RW-1:0];
        ovf_d    = ovf_q | acc_total[RW];
        done_d   = 1'b1;
        busy_d   = 1'b0;
        state_d  = S_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      opc_q    <= '0;
      opd_q    <= '0;
      acc_op_q <= 1'b0;
      p_ab_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      opc_q    <= opc_d;
      opd_q    <= opd_d;
      acc_op_q <= acc_op_d;
      p_ab_q   <= p_ab_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign ovf    = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_seq_dot2_mac.sv
// ============================================================
// tb_seq_dot2_mac: directed vector table plus hand-written corner sequences
// Rev 1.0
// ============================================================
`default_nettype none

module tb_seq_dot2_mac;

  localparam int W  = 4;
  localparam int RW = 12;

  logic          clk;
  logic          rst;
  logic          start;
  logic          acc;
  logic          clr;
  logic [W-1:0]  a, b, c, d;
  logic          busy;
  logic          done;
  logic [RW-1:0] result;
  logic          ovf;

  int n_cmp;
  int n_bad;

  typedef struct {
    logic [W-1:0] a, b, c, d;
    logic         acc;
    logic         clr;
    int           exp_result;
    logic         exp_ovf;
  } vec_t;

  vec_t tbl[$];

  seq_dot2_mac #(.W(W), .RW(RW)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .acc    (acc),
    .clr    (clr),
    .a      (a),
    .b      (b),
    .c      (c),
    .d      (d),
    .busy   (busy),
    .done   (done),
    .result (result),
    .ovf    (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input int ta, input int tb, input int tc, input int td,
                              input logic tacc, input logic tclr, input int er, input logic eo);
    vec_t v;
    v.a = W'(ta); v.b = W'(tb); v.c = W'(tc); v.d = W'(td);
    v.acc = tacc; v.clr = tclr; v.exp_result = er; v.exp_ovf = eo;
    return v;
  endfunction

  // Returns edges from the sampling edge to done, and number of busy cycles seen.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb2,
                        input logic [W-1:0] tc, input logic [W-1:0] td,
                        input logic tacc, output int lat, output int bcnt);
    @(negedge clk);
    a = ta; b = tb2; c = tc; d = td; acc = tacc; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat  = 0;
    bcnt = busy ? 1 : 0;
    while (!done && lat < 30) begin
      @(posedge clk);
      #1;
      lat++;
      if (busy) bcnt++;
    end
  endtask

  task automatic do_clr();
    @(negedge clk);
    clr = 1'b1;
    @(posedge clk);
    #1 clr = 1'b0;
  endtask

  initial begin
    int lat, bcnt, dcnt, bsy;
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1; start = 1'b0; acc = 1'b0; clr = 1'b0;
    a = '0; b = '0; c = '0; d = '0;

    repeat (2) @(posedge clk);
    #1;
    check("reset_busy",   busy,   0);
    check("reset_done",   done,   0);
    check("reset_result", result, 0);
    check("reset_ovf",    ovf,    0);
    @(negedge clk);
    rst = 1'b0;

    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(7, 7, 7, 7, 0, 0, 98, 0));
    tbl.push_back(mk(7, 7, 7, 7, 1, 0, 196, 0));
    tbl.push_back(mk(7, 7, 7, 7, 1, 0, 294, 0));
    tbl.push_back(mk(3, 2, 1, 5, 0, 0, 11, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(15, 15, 0, 9, 0, 0, 225, 0));
    tbl.push_back(mk(0, 4, 15, 15, 1, 0, 450, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0));
    for (int k = 1; k <= 9; k++)
      tbl.push_back(mk(15, 15, 15, 15, 1, 0, 450 * k, 0));
    tbl.push_back(mk(15, 15, 15, 15, 1, 0, 404, 1));
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 1, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0));

    foreach (tbl[i]) begin
      if (tbl[i].clr) begin
        do_clr();
        check($sformatf("v%0d_clr_busy", i), busy, 0);
      end else begin
        run_op(tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].d, tbl[i].acc, lat, bcnt);
        check($sformatf("v%0d_latency", i), lat, 9);
        check($sformatf("v%0d_busy_cycles", i), bcnt, 9);
      end
      check($sformatf("v%0d_result", i), result, tbl[i].exp_result);
      check($sformatf("v%0d_ovf", i), ovf, tbl[i].exp_ovf);
    end

    // Start re-pulsed with other operands while busy: 2*3 + 4*5 = 26.
    @(negedge clk);
    a = 2; b = 3; c = 4; d = 5; acc = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = 0;
    while (!done && lat < 30) begin
      @(posedge clk);
      #1;
      lat++;
      if (lat == 2 || lat == 4) begin
        a = 15; b = 15; c = 15; d = 15; acc = 1'b1; start = 1'b1;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    check("repulse_latency", lat, 9);
    check("repulse_result", result, 26);

    // Hold between done pulses.
    repeat (3) @(posedge clk);
    #1;
    check("hold_result", result, 26);
    check("hold_done", done, 0);

    // Reset in the 4th MUL_AB cycle aborts with no done.
    @(negedge clk);
    a = 9; b = 9; c = 9; d = 9; acc = 1'b1; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_result", result, 0);
    check("midrst_ovf", ovf, 0);
    @(negedge clk);
    rst = 1'b0;
    dcnt = 0; bsy = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (done) dcnt++;
      if (busy) bsy++;
    end
    check("midrst_no_done", dcnt, 0);
    check("midrst_no_busy", bsy, 0);
    run_op(3, 2, 1, 5, 1'b1, lat, bcnt);
    check("restart_latency", lat, 9);
    check("restart_result", result, 11);

    // clr and start together: clr wins, nothing starts.
    run_op(7, 7, 7, 7, 1'b0, lat, bcnt);
    check("pre_clr_result", result, 98);
    @(negedge clk);
    a = 15; b = 15; c = 15; d = 15; acc = 1'b1; clr = 1'b1; start = 1'b1;
    @(posedge clk);
    #1 clr = 1'b0; start = 1'b0;
    check("clrstart_result", result, 0);
    check("clrstart_busy", busy, 0);
    dcnt = 0; bsy = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (done) dcnt++;
      if (busy) bsy++;
    end
    check("clrstart_no_done", dcnt, 0);
    check("clrstart_no_busy", bsy, 0);
    check("clrstart_result_after", result, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
